// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point FFT sequencer: transform size,
// sequencer state encoding and the twiddle-index width used by the LUT.
package fft16_pkg;
    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int TW_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        WAIT,
        UNLOAD,
        DONE
    } state_t;
endpackage

// File: rtl/fft16_bf_addr_gen.sv
// Radix-2 DIF butterfly operand and twiddle addressing for one
// (stage, butterfly index) pair; purely combinational.
module fft16_bf_addr_gen
    import fft16_pkg::*;
(
    input  logic [1:0]       stage,
    input  logic [2:0]       j,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [TW_W-1:0]  tw_index
);
    logic [3:0] span;
    logic [2:0] pos_mask;
    logic [2:0] pos;

    // span is a power of two, so group/position split is a mask and the
    // group base 2*span*group is just the upper bits of j shifted left once.
    always_comb begin
        span     = 4'd8 >> stage;
        pos_mask = 3'd7 >> stage;
        pos      = j & pos_mask;
        addr_a   = {j & ~pos_mask, 1'b0} | {1'b0, pos};
        addr_b   = addr_a + span;
        tw_index = pos << stage;
    end
endmodule

// File: rtl/fft16_sequencer.sv
// Control sequencer for an in-place 16-point radix-2 DIF FFT: loads samples,
// issues 4 stages of 8 butterflies with pipeline drain, then reads out bit-reversed.
module fft16_sequencer
    import fft16_pkg::*;
#(
    parameter int BF_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [TW_W-1:0]  bf_tw_index,
    output logic [1:0]       bf_stage,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG2N-1:0] out_addr,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    state_t           state;
    logic [LOG2N-1:0] load_cnt;
    logic [2:0]       bf_cnt;
    logic [1:0]       stage;
    logic [LOG2N-1:0] k;
    logic [3:0]       wait_cnt;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [TW_W-1:0]  gen_tw;

    function automatic logic [LOG2N-1:0] bit_rev4(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    fft16_bf_addr_gen u_addr_gen (
        .stage    (stage),
        .j        (bf_cnt),
        .addr_a   (gen_a),
        .addr_b   (gen_b),
        .tw_index (gen_tw)
    );

    assign wr_en       = in_valid & in_ready;
    assign wr_addr     = load_cnt;
    assign bf_stage    = stage;
    // Addresses read as zero whenever no butterfly is being offered.
    assign bf_addr_a   = bf_valid ? gen_a  : '0;
    assign bf_addr_b   = bf_valid ? gen_b  : '0;
    assign bf_tw_index = bf_valid ? gen_tw : '0;
    assign out_addr    = bit_rev4(k);
    assign out_last    = out_valid & (k == 4'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            load_cnt  <= '0;
            bf_cnt    <= '0;
            stage     <= '0;
            k         <= '0;
            wait_cnt  <= '0;
            in_ready  <= 1'b0;
            bf_valid  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        load_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (wr_en) begin
                        if (load_cnt == 4'(N - 1)) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            bf_valid <= 1'b1;
                            load_cnt <= '0;
                            stage    <= '0;
                            bf_cnt   <= '0;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (bf_ready) begin
                        if (bf_cnt == 3'(N / 2 - 1)) begin
                            state    <= WAIT;
                            bf_valid <= 1'b0;
                            bf_cnt   <= '0;
                            wait_cnt <= '0;
                        end else begin
                            bf_cnt <= bf_cnt + 1'b1;
                        end
                    end
                end
                // Let the external butterfly pipeline drain before the next
                // stage reads results written by this one.
                WAIT: begin
                    if (wait_cnt == 4'(BF_LAT - 1)) begin
                        wait_cnt <= '0;
                        if (stage == 2'(LOG2N - 1)) begin
                            state     <= UNLOAD;
                            out_valid <= 1'b1;
                            k         <= '0;
                        end else begin
                            state    <= COMPUTE;
                            stage    <= stage + 1'b1;
                            bf_cnt   <= '0;
                            bf_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (k == 4'(N - 1)) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            k         <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    stage <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft16_sequencer.sv
// Directed testbench for fft16_sequencer: main instance with BF_LAT=3 and a
// second instance with BF_LAT=1 exercised end to end.
module tb_fft16_sequencer;
    localparam int BF_LAT = 3;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, bf_ready, out_ready;
    logic       in_ready, wr_en, bf_valid, out_valid, out_last, busy, done;
    logic [3:0] wr_addr, bf_addr_a, bf_addr_b, out_addr;
    logic [2:0] bf_tw_index;
    logic [1:0] bf_stage;

    logic       l_start, l_in_valid, l_bf_ready, l_out_ready;
    logic       l_in_ready, l_wr_en, l_bf_valid, l_out_valid, l_out_last, l_busy, l_done;
    logic [3:0] l_wr_addr, l_bf_addr_a, l_bf_addr_b, l_out_addr;
    logic [2:0] l_bf_tw_index;
    logic [1:0] l_bf_stage;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft16_sequencer #(.BF_LAT(BF_LAT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
        .bf_tw_index(bf_tw_index), .bf_stage(bf_stage),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done)
    );

    fft16_sequencer #(.BF_LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset), .start(l_start),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .wr_en(l_wr_en), .wr_addr(l_wr_addr),
        .bf_valid(l_bf_valid), .bf_ready(l_bf_ready), .bf_addr_a(l_bf_addr_a), .bf_addr_b(l_bf_addr_b),
        .bf_tw_index(l_bf_tw_index), .bf_stage(l_bf_stage),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_addr(l_out_addr), .out_last(l_out_last),
        .busy(l_busy), .done(l_done)
    );

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; bf_ready = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, wr_en, bf_valid, out_valid, out_last, busy, done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 0000000",
                     {in_ready, wr_en, bf_valid, out_valid, out_last, busy, done});
        end
        checks++;
        if ({wr_addr, bf_addr_a, bf_addr_b, bf_tw_index, bf_stage, out_addr} !== 21'b0) begin
            errors++;
            $display("FAIL reset_addrs: got %h, want 0",
                     {wr_addr, bf_addr_a, bf_addr_b, bf_tw_index, bf_stage, out_addr});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b in_ready=%b, want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_start_at_reset_release();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_at_release: in_ready=%b busy=%b, want 1 1", in_ready, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_gaps();
        int acc = 0;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (acc < 16 && cyc < 100) begin
            in_valid = (cyc % 3 != 1);
            #1;
            checks++;
            if (in_ready !== 1'b1 || wr_en !== in_valid) begin
                errors++;
                $display("FAIL load_wr_en cyc%0d: in_ready=%b wr_en=%b, want 1 %b", cyc, in_ready, wr_en, in_valid);
            end
            if (in_valid) begin
                checks++;
                if (wr_addr !== 4'(acc)) begin
                    errors++;
                    $display("FAIL load_wr_addr: got %0d, want %0d", wr_addr, acc);
                end
                acc++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (acc != 16) begin
            errors++;
            $display("FAIL load_timeout: accepted %0d, want 16", acc);
        end
        checks++;
        if (bf_valid !== 1'b1 || in_ready !== 1'b0 || bf_stage !== 2'd0 || bf_addr_a !== 4'd0 || bf_addr_b !== 4'd8) begin
            errors++;
            $display("FAIL compute_entry: bf_valid=%b in_ready=%b stage=%0d a=%0d b=%0d, want 1 0 0 0 8",
                     bf_valid, in_ready, bf_stage, bf_addr_a, bf_addr_b);
        end
    endtask

    task automatic test_compute();
        int s = 0, j = 0, hs = 0, stall = 0, cyc = 0, wl;
        int span, pos, ea, eb, et;
        int cs[4] = '{0, 1, 2, 3};
        int cj[4] = '{3, 5, 3, 7};
        int ca[4] = '{3, 9, 5, 14};
        int cb[4] = '{11, 13, 7, 15};
        int ct[4] = '{3, 2, 4, 0};
        logic [13:0] held = '0;
        while (s < 4 && cyc < 400) begin
            @(negedge clk);
            start = (cyc % 7 == 3);
            bf_ready = !(s == 1 && j == 2 && stall < 5);
            #1;
            span = 8 >> s;
            pos  = j % span;
            ea   = 2 * span * (j / span) + pos;
            eb   = ea + span;
            et   = (pos << s) % 8;
            checks++;
            if (bf_valid !== 1'b1 || bf_stage !== 2'(s) || bf_addr_a !== 4'(ea) ||
                bf_addr_b !== 4'(eb) || bf_tw_index !== 3'(et)) begin
                errors++;
                $display("FAIL bf_issue s%0d j%0d: valid=%b stage=%0d a=%0d b=%0d tw=%0d, want 1 %0d %0d %0d %0d",
                         s, j, bf_valid, bf_stage, bf_addr_a, bf_addr_b, bf_tw_index, s, ea, eb, et);
            end
            for (int t = 0; t < 4; t++) begin
                if (s == cs[t] && j == cj[t] && bf_ready) begin
                    checks++;
                    if (bf_addr_a !== 4'(ca[t]) || bf_addr_b !== 4'(cb[t]) || bf_tw_index !== 3'(ct[t])) begin
                        errors++;
                        $display("FAIL addr_table s%0d j%0d: a=%0d b=%0d tw=%0d, want %0d %0d %0d",
                                 s, j, bf_addr_a, bf_addr_b, bf_tw_index, ca[t], cb[t], ct[t]);
                    end
                end
            end
            if (!bf_ready) begin
                if (stall == 0) begin
                    held = {bf_valid, bf_stage, bf_addr_a, bf_addr_b, bf_tw_index};
                end else begin
                    checks++;
                    if ({bf_valid, bf_stage, bf_addr_a, bf_addr_b, bf_tw_index} !== held) begin
                        errors++;
                        $display("FAIL stall_stable cycle%0d: got %h, want %h", stall,
                                 {bf_valid, bf_stage, bf_addr_a, bf_addr_b, bf_tw_index}, held);
                    end
                end
                stall++;
            end else begin
                hs++;
                j++;
                if (j == 8) begin
                    wl = 0;
                    @(negedge clk);
                    start = 1'b0; bf_ready = 1'b0;
                    #1;
                    while (bf_valid !== 1'b1 && out_valid !== 1'b1 && wl < 40) begin
                        wl++;
                        @(negedge clk);
                        start = 1'b0; bf_ready = 1'b0;
                        #1;
                    end
                    checks++;
                    if (wl != BF_LAT) begin
                        errors++;
                        $display("FAIL wait_len stage%0d: got %0d, want %0d", s, wl, BF_LAT);
                    end
                    s++;
                    j = 0;
                end
            end
            cyc++;
        end
        start = 1'b0;
        bf_ready = 1'b0;
        checks++;
        if (hs != 32 || s != 4) begin
            errors++;
            $display("FAIL bf_total: handshakes=%0d stages=%0d, want 32 4", hs, s);
        end
    endtask

    task automatic test_unload();
        int exp_addr[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            start = (k == 5);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 4'(exp_addr[k]) || out_last !== (k == 15) || done !== 1'b0) begin
                errors++;
                $display("FAIL unload k%0d: valid=%b addr=%0d last=%b done=%b, want 1 %0d %b 0",
                         k, out_valid, out_addr, out_last, done, exp_addr[k], (k == 15));
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b out_valid=%b, want 1 1 0", done, busy, out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL back_to_idle %0d: done=%b busy=%b in_ready=%b out_valid=%b, want 0 0 0 0",
                         i, done, busy, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_compute();
        int cyc = 0;
        bit found = 1'b0;
        test_load_gaps();
        while (!found && cyc < 200) begin
            @(negedge clk);
            bf_ready = 1'b1;
            #1;
            if (bf_valid === 1'b1 && bf_stage === 2'd2 && bf_addr_a === 4'd8) found = 1'b1;
            cyc++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_stage2_j4: got not reached, want reached");
        end
        reset = 1'b1;
        bf_ready = 1'b0;
        #1;
        checks++;
        if ({in_ready, wr_en, bf_valid, out_valid, out_last, busy, done} !== 7'b0 ||
            {wr_addr, bf_addr_a, bf_addr_b, bf_tw_index, bf_stage, out_addr} !== 21'b0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b addrs=%h, want 0 0",
                     {in_ready, wr_en, bf_valid, out_valid, out_last, busy, done},
                     {wr_addr, bf_addr_a, bf_addr_b, bf_tw_index, bf_stage, out_addr});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bf_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%b bf_valid=%b, want 0 0", busy, bf_valid);
        end
        test_load_gaps();
        test_compute();
        test_unload();
    endtask

    task automatic test_bf_lat1();
        int hs = 0, waits = 0, run = 0, outs = 0, dones = 0, loads = 0, cyc = 0;
        int s, j, span, pos, ea;
        int exp_addr[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        bit in_comp = 1'b0, fin = 1'b0;
        @(negedge clk);
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0; l_in_valid = 1'b1; l_bf_ready = 1'b1; l_out_ready = 1'b1;
        while (!fin && cyc < 300) begin
            #1;
            if (l_wr_en === 1'b1) begin
                checks++;
                if (l_in_ready !== 1'b1 || l_wr_addr !== 4'(loads)) begin
                    errors++;
                    $display("FAIL lat1_load: in_ready=%b wr_addr=%0d, want 1 %0d", l_in_ready, l_wr_addr, loads);
                end
                loads++;
            end
            if (l_bf_valid === 1'b1 || l_out_valid === 1'b1) begin
                if (run > 0) begin
                    checks++;
                    if (run != 1) begin
                        errors++;
                        $display("FAIL lat1_wait_len: got %0d, want 1", run);
                    end
                    waits++;
                    run = 0;
                end
                if (l_bf_valid === 1'b1) begin
                    s = hs / 8; j = hs % 8; span = 8 >> s; pos = j % span;
                    ea = 2 * span * (j / span) + pos;
                    checks++;
                    if (l_bf_stage !== 2'(s) || l_bf_addr_a !== 4'(ea) || l_bf_addr_b !== 4'(ea + span) ||
                        l_bf_tw_index !== 3'((pos << s) % 8)) begin
                        errors++;
                        $display("FAIL lat1_bf hs%0d: stage=%0d a=%0d b=%0d tw=%0d, want %0d %0d %0d %0d",
                                 hs, l_bf_stage, l_bf_addr_a, l_bf_addr_b, l_bf_tw_index, s, ea, ea + span, (pos << s) % 8);
                    end
                    hs++;
                    in_comp = 1'b1;
                end
                if (l_out_valid === 1'b1) begin
                    checks++;
                    if (outs < 16 && (l_out_addr !== 4'(exp_addr[outs]) || l_out_last !== (outs == 15))) begin
                        errors++;
                        $display("FAIL lat1_unload k%0d: addr=%0d last=%b, want %0d %b",
                                 outs, l_out_addr, l_out_last, exp_addr[outs], (outs == 15));
                    end
                    outs++;
                end
            end else if (in_comp && l_busy === 1'b1 && l_done !== 1'b1) begin
                run++;
            end
            if (l_done === 1'b1) dones++;
            if (dones > 0 && l_busy === 1'b0) fin = 1'b1;
            cyc++;
            @(negedge clk);
        end
        l_in_valid = 1'b0; l_bf_ready = 1'b0; l_out_ready = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL lat1_timeout: got unfinished after %0d cycles, want finished", cyc);
        end
        checks++;
        if (hs != 32 || waits != 4 || outs != 16 || dones != 1 || loads != 16) begin
            errors++;
            $display("FAIL lat1_counts: hs=%0d waits=%0d outs=%0d dones=%0d loads=%0d, want 32 4 16 1 16",
                     hs, waits, outs, dones, loads);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; bf_ready = 1'b0; out_ready = 1'b0;
        l_start = 1'b0; l_in_valid = 1'b0; l_bf_ready = 1'b0; l_out_ready = 1'b0;
        test_reset();
        test_start_at_reset_release();
        test_load_gaps();
        test_compute();
        test_unload();
        test_reset_mid_compute();
        test_bf_lat1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft16_sequencer.md
FFT16_SEQUENCER -- requirements
Module: fft16_sequencer

Interface
REQ-001 Parameter BF_LAT, default 3, cycles from butterfly issue to result write-back in the external butterfly pipeline (range 1..15).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  begin one 16-point transform; sampled only in IDLE.
REQ-005 in_valid / in_ready  in/out  1/1  input-sample handshake (LOAD phase).
REQ-006 wr_en / wr_addr  out  1/4  sample-buffer write strobe and natural-order address.
REQ-007 bf_valid / bf_ready  out/in  1/1  butterfly issue handshake.
REQ-008 bf_addr_a / bf_addr_b  out  4/4  butterfly operand addresses.
REQ-009 bf_tw_index  out  3  twiddle LUT index, W16^k with k=0..7.
REQ-010 bf_stage  out  2  current radix-2 stage, 0..3.
REQ-011 out_valid / out_ready / out_addr / out_last  out/in/out/out  1/1/4/1  result read-out handshake, bit-reversed read address, last flag.
REQ-012 busy / done  out  1/1  transform in progress; one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, COMPUTE, WAIT, UNLOAD, DONE.
REQ-014 IDLE->LOAD on start=1; start SHALL be ignored in all other states.
REQ-015 LOAD: in_ready=1; wr_en = in_valid & in_ready (combinational); wr_addr = load count 0..15; 16th accepted sample -> COMPUTE, bf_stage=0, butterfly count j=0.
REQ-016 COMPUTE: bf_valid=1; outputs SHALL hold stable until bf_valid & bf_ready; j advances only on handshake.
REQ-017 Addressing (DIF): span = 8>>stage; group = j/span; pos = j%span; bf_addr_a = 2*span*group + pos; bf_addr_b = bf_addr_a + span; bf_tw_index = (pos<<stage) mod 8.
REQ-018 Handshake on j=7 -> WAIT; bf_valid=0 in WAIT.
REQ-019 WAIT SHALL last exactly BF_LAT cycles, then stage<3 -> COMPUTE with stage+1, j=0; stage=3 -> UNLOAD, k=0.
REQ-020 UNLOAD: out_valid=1; out_addr = bit-reverse(k); out_last = (k==15); k advances on out_valid & out_ready; handshake at k=15 -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 busy = 1 in every state except IDLE.
REQ-023 Stalls (in_valid=0, bf_ready=0, out_ready=0) SHALL hold all counters and outputs indefinitely without timeout.
REQ-024 Counters SHALL never wrap inside a phase; k, j, load count cleared on phase entry.

Reset
REQ-025 reset=1 at any time, including mid-LOAD/COMPUTE/UNLOAD, SHALL force IDLE immediately and clear all counters.
REQ-026 Reset values: in_ready, wr_en, bf_valid, out_valid, out_last, busy, done = 0; wr_addr, bf_addr_a, bf_addr_b, bf_tw_index, bf_stage, out_addr = 0.
REQ-027 A start asserted in the cycle reset deasserts SHALL be honoured on the next clock edge.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding, N=16, LOG2N=4, and the 3-bit twiddle-index width shared with the twiddle LUT.
REQ-029 One sub-module, fft16_bf_addr_gen, SHALL compute bf_addr_a/bf_addr_b/bf_tw_index combinationally from stage and j; bit-reverse stays in the top.

Verification
REQ-030 Reset mid-COMPUTE (stage 2, j=4) -> next cycle IDLE, busy=0, all outputs 0; fresh start runs a full transform correctly.
REQ-031 start, 16 samples with in_valid gaps -> wr_addr 0..15 in order, wr_en only on accepted beats, COMPUTE entered after 16th.
REQ-032 Address checks: stage0 j=3 -> a=3,b=11,tw=3; stage1 j=5 -> a=9,b=13,tw=2; stage2 j=3 -> a=5,b=7,tw=4; stage3 j=7 -> a=14,b=15,tw=0.
REQ-033 bf_ready held low 5 cycles at stage1 j=2 -> outputs stable; total 32 butterfly handshakes, 4 WAIT periods of exactly BF_LAT cycles each (also run BF_LAT=1).
REQ-034 UNLOAD with out_ready always high -> out_addr 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_last only on 15; done pulses once, then IDLE.
REQ-035 start pulsed during COMPUTE and UNLOAD -> no effect on sequence or counters.
